// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register scoreboard with RAW/capacity stall and taken-branch flush sequencing
module hazard_ctrl #(
  parameter int NREGS        = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn_i,
  input  logic [4:0] ID_rs1_addr_i,
  input  logic [4:0] ID_rs2_addr_i,
  input  logic       ID_rs1_used_i,
  input  logic       ID_rs2_used_i,
  input  logic [4:0] ID_rd_addr_i,
  input  logic       ID_rd_write_i,
  input  logic       ID_EX_give_i,
  input  logic       EX_ID_get_i,
  input  logic       EX_MEM_give_i,
  input  logic       MEM_EX_get_i,
  input  logic       branch_taken_i,
  input  logic       WB_retire_i,
  input  logic [4:0] WB_rd_addr_i,
  output logic       stall_o,
  output logic       flush_o,
  output logic [5:0] inflight_o,
  output logic       err_o
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state;
  logic [3:0]       fcnt;
  logic [CNT_W-1:0] cnt [NREGS];
  logic             commit, raw, full, issue, rd_ok, wb_ok, same, wb_zero, inc_e, dec_e;
  logic [NREGS-1:0] inc_v, dec_v;
  logic [5:0]       infl_nx;
  assign commit  = EX_MEM_give_i & MEM_EX_get_i & branch_taken_i;
  assign raw     = (ID_rs1_used_i && ID_rs1_addr_i != 5'd0 && cnt[ID_rs1_addr_i] != '0) ||
                   (ID_rs2_used_i && ID_rs2_addr_i != 5'd0 && cnt[ID_rs2_addr_i] != '0);
  assign full    = ID_rd_write_i && ID_rd_addr_i != 5'd0 && cnt[ID_rd_addr_i] == CMAX;
  assign stall_o = raw | full | commit | (state == FLUSH);
  assign issue   = ID_EX_give_i & EX_ID_get_i & ~stall_o;
  assign rd_ok   = issue & ID_rd_write_i & (ID_rd_addr_i != 5'd0);
  assign wb_ok   = WB_retire_i & (WB_rd_addr_i != 5'd0);
  // A same-register issue and retire cancel out and leave the count untouched
  assign same    = rd_ok & wb_ok & (ID_rd_addr_i == WB_rd_addr_i);
  assign wb_zero = cnt[WB_rd_addr_i] == '0;
  assign inc_e   = rd_ok & ~same;
  assign dec_e   = wb_ok & ~same & ~wb_zero;
  // Decode per-register increment/decrement strobes and the next in-flight total
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (inc_e) inc_v[ID_rd_addr_i] = 1'b1;
    if (dec_e) dec_v[WB_rd_addr_i] = 1'b1;
    infl_nx = (inc_e & ~dec_e) ? ((inflight_o == 6'd63) ? inflight_o : inflight_o + 6'd1) :
              (dec_e & ~inc_e & inflight_o != 6'd0) ? inflight_o - 6'd1 : inflight_o;
  end
  // Scoreboard counters, in-flight total and sticky underflow error
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      inflight_o <= '0;
      err_o      <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (inc_v[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec_v[i]) cnt[i] <= cnt[i] - 1'b1;
      inflight_o <= infl_nx;
      if (wb_ok & ~same & wb_zero) err_o <= 1'b1;
    end
  end
  // Flush sequencer: a taken branch holds flush_o high for FLUSH_CYCLES cycles
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state   <= RUN;
      fcnt    <= '0;
      flush_o <= 1'b0;
    end else begin
      case (state)
        RUN: if (commit) begin
          state   <= FLUSH;
          fcnt    <= 4'(FLUSH_CYCLES - 1);
          flush_o <= 1'b1;
        end
        FLUSH: if (fcnt == 4'd0) begin
          state   <= RUN;
          flush_o <= 1'b0;
        end else fcnt <= fcnt - 4'd1;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       resetn_i;
  logic [4:0] ID_rs1_addr_i, ID_rs2_addr_i, ID_rd_addr_i, WB_rd_addr_i;
  logic       ID_rs1_used_i, ID_rs2_used_i, ID_rd_write_i;
  logic       ID_EX_give_i, EX_ID_get_i, EX_MEM_give_i, MEM_EX_get_i, branch_taken_i, WB_retire_i;
  logic       stall_o, flush_o, err_o;
  logic [5:0] inflight_o;
  int         n_chk = 0;
  int         n_fail = 0;
  typedef struct {
    string      nm;
    logic [3:0] m;
    logic       s;
    logic       f;
    logic [5:0] i;
    logic       e;
  } exp_t;
  exp_t q[$];
  hazard_ctrl dut (
    .clk(clk), .resetn_i(resetn_i),
    .ID_rs1_addr_i(ID_rs1_addr_i), .ID_rs2_addr_i(ID_rs2_addr_i),
    .ID_rs1_used_i(ID_rs1_used_i), .ID_rs2_used_i(ID_rs2_used_i),
    .ID_rd_addr_i(ID_rd_addr_i), .ID_rd_write_i(ID_rd_write_i),
    .ID_EX_give_i(ID_EX_give_i), .EX_ID_get_i(EX_ID_get_i),
    .EX_MEM_give_i(EX_MEM_give_i), .MEM_EX_get_i(MEM_EX_get_i),
    .branch_taken_i(branch_taken_i), .WB_retire_i(WB_retire_i), .WB_rd_addr_i(WB_rd_addr_i),
    .stall_o(stall_o), .flush_o(flush_o), .inflight_o(inflight_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Monitor: pops every expectation queued for this cycle and compares at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      if (x.m[3]) chk({x.nm, ".stall"}, {5'd0, stall_o}, {5'd0, x.s});
      if (x.m[2]) chk({x.nm, ".flush"}, {5'd0, flush_o}, {5'd0, x.f});
      if (x.m[1]) chk({x.nm, ".inflight"}, inflight_o, x.i);
      if (x.m[0]) chk({x.nm, ".err"}, {5'd0, err_o}, {5'd0, x.e});
    end
  end
  task automatic idle();
    {ID_rs1_addr_i, ID_rs2_addr_i, ID_rd_addr_i, WB_rd_addr_i} = '0;
    {ID_rs1_used_i, ID_rs2_used_i, ID_rd_write_i} = '0;
    {ID_EX_give_i, EX_ID_get_i, EX_MEM_give_i, MEM_EX_get_i, branch_taken_i, WB_retire_i} = '0;
  endtask
  task automatic cyc(input string nm, input logic [3:0] m, input logic s, input logic f,
                     input logic [5:0] i, input logic e);
    q.push_back('{nm, m, s, f, i, e});
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic iss(input logic [4:0] rd);
    ID_EX_give_i = 1'b1; EX_ID_get_i = 1'b1; ID_rd_write_i = 1'b1; ID_rd_addr_i = rd;
  endtask
  task automatic ret(input logic [4:0] rd);
    WB_retire_i = 1'b1; WB_rd_addr_i = rd;
  endtask
  task automatic br();
    EX_MEM_give_i = 1'b1; MEM_EX_get_i = 1'b1; branch_taken_i = 1'b1;
  endtask
  initial begin
    idle();
    resetn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", 4'hF, 0, 0, 0, 0);
    resetn_i = 1'b1;
    iss(5);                                   cyc("iss5", 4'hF, 0, 0, 0, 0);
    ID_rs1_used_i = 1; ID_rs1_addr_i = 5; ID_EX_give_i = 1; EX_ID_get_i = 1;
                                              cyc("raw5", 4'b1010, 1, 0, 1, 0);
    ID_rs1_used_i = 1; ID_rs1_addr_i = 5; ret(5);
                                              cyc("raw5_wb", 4'b1010, 1, 0, 1, 0);
    ID_rs1_used_i = 1; ID_rs1_addr_i = 5; ID_EX_give_i = 1; EX_ID_get_i = 1;
                                              cyc("raw5_clr", 4'hF, 0, 0, 0, 0);
    iss(0); ID_rs1_used_i = 1; ID_rs2_used_i = 1;
                                              cyc("x0a", 4'hB, 0, 0, 0, 0);
    iss(0); ID_rs1_used_i = 1; ID_rs2_used_i = 1; ret(0);
                                              cyc("x0b", 4'hB, 0, 0, 0, 0);
                                              cyc("x0c", 4'hB, 0, 0, 0, 0);
    iss(7);                                   cyc("x7a", 4'b1010, 0, 0, 0, 0);
    iss(7);                                   cyc("x7b", 4'b1010, 0, 0, 1, 0);
    iss(7);                                   cyc("x7c", 4'b1010, 0, 0, 2, 0);
    iss(7);                                   cyc("x7full", 4'b1010, 1, 0, 3, 0);
    iss(7); ret(7);                           cyc("x7full_wb", 4'b1010, 1, 0, 3, 0);
    iss(7);                                   cyc("x7free", 4'b1010, 0, 0, 2, 0);
    ret(7);                                   cyc("x7d1", 4'b1010, 0, 0, 3, 0);
    ret(7);                                   cyc("x7d2", 4'b1010, 0, 0, 2, 0);
    ret(7);                                   cyc("x7d3", 4'b1010, 0, 0, 1, 0);
                                              cyc("x7done", 4'hB, 0, 0, 0, 0);
    iss(9);                                   cyc("x9a", 4'b1010, 0, 0, 0, 0);
    iss(9); ret(9);                           cyc("x9same", 4'b1011, 0, 0, 1, 0);
    ID_rs1_used_i = 1; ID_rs1_addr_i = 9;    cyc("x9hold", 4'b1011, 1, 0, 1, 0);
    ret(9);                                   cyc("x9ret", 4'b1010, 0, 0, 1, 0);
    ret(12);                                  cyc("x12ret", 4'b0011, 0, 0, 0, 0);
                                              cyc("err_set", 4'b0011, 0, 0, 0, 1);
                                              cyc("err_sticky", 4'b0011, 0, 0, 0, 1);
    br(); iss(3);                             cyc("brT", 4'hE, 1, 0, 0, 0);
    iss(3);                                   cyc("brT1", 4'hE, 1, 1, 0, 0);
    iss(3);                                   cyc("brT2", 4'hE, 1, 1, 0, 0);
    iss(3);                                   cyc("brT3", 4'hE, 0, 0, 0, 0);
    ret(3);                                   cyc("brT4", 4'hE, 0, 0, 1, 0);
    br();                                     cyc("br2", 4'hE, 1, 0, 0, 0);
    br();                                     cyc("br2_ign", 4'hC, 1, 1, 0, 0);
                                              cyc("br2_2", 4'hC, 1, 1, 0, 0);
                                              cyc("br2_3", 4'hC, 0, 0, 0, 0);
    br();                                     cyc("br3", 4'hC, 1, 0, 0, 0);
                                              cyc("br3_1", 4'hC, 1, 1, 0, 0);
    resetn_i = 1'b0;                          cyc("rst_flush", 4'hF, 0, 0, 0, 0);
    resetn_i = 1'b1;                          cyc("post_rst", 4'hF, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
